// File: rtl/mem_buffer_unit.sv
// Memory buffer register with a valid/ready read handshake, a posted write FIFO and a busy stall.
// Optional store-to-load forwarding from the write FIFO is enabled by defining MBR_FWD_EN.
module mem_buffer_unit #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 8,
    parameter int CS_W       = 32,
    parameter int LD_MEM_BIT = 3,
    parameter int LD_ACC_BIT = 20,
    parameter int ST_BIT     = 19,
    parameter int WB_DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [CS_W-1:0]          control_signal,
    input  logic [ADDR_W-1:0]        addr_in,
    input  logic [DATA_W-1:0]        from_memory,
    input  logic                     mem_rvalid,
    input  logic [DATA_W-1:0]        from_ACC,
    output logic                     mem_rreq,
    output logic [ADDR_W-1:0]        mem_raddr,
    output logic                     mem_wvalid,
    input  logic                     mem_wready,
    output logic [DATA_W-1:0]        to_memory,
    output logic [ADDR_W-1:0]        mem_waddr,
    output logic                     busy,
    output logic [ADDR_W-1:0]        to_PC,
    output logic [DATA_W-ADDR_W-1:0] to_IR,
    output logic [DATA_W-1:0]        to_BR,
    output logic [ADDR_W-1:0]        to_MAR
);

    // state   | meaning
    // IDLE    | accepting commands
    // DRAIN   | load pending, emptying write FIFO first (read-after-write order)
    // RD_WAIT | read request outstanding, waiting for mem_rvalid
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DRAIN   = 2'd1,
        S_RD_WAIT = 2'd2
    } state_t;

    localparam int PTR_W = $clog2(WB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    state_t              state;
    logic [DATA_W-1:0]   mbr_q;
    logic [DATA_W-1:0]   wb_data [WB_DEPTH];
    logic [ADDR_W-1:0]   wb_addr [WB_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    wb_count;
    logic [CNT_W-1:0]    wb_count_nxt;

    logic cmd_ld_mem, cmd_ld_acc, cmd_st;
    logic wb_empty, wb_full, st_full;
    logic accept, push, pop;
    logic fwd_take;
    logic [DATA_W-1:0] fwd_data;
    logic unused_cs;

    assign cmd_ld_mem = control_signal[LD_MEM_BIT];
    assign cmd_ld_acc = control_signal[LD_ACC_BIT];
    assign cmd_st     = control_signal[ST_BIT];
    assign unused_cs  = ^control_signal;

    assign wb_empty = (wb_count == '0);
    assign wb_full  = (wb_count == CNT_W'(WB_DEPTH));
    assign st_full  = cmd_st & wb_full;

`ifdef MBR_FWD_EN
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_hit_data;

    // Walk oldest to youngest so the youngest matching entry wins.
    always_comb begin
        fwd_hit      = 1'b0;
        fwd_hit_data = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            if ((CNT_W'(i) < wb_count) && (wb_addr[rd_ptr + PTR_W'(i)] == addr_in)) begin
                fwd_hit      = 1'b1;
                fwd_hit_data = wb_data[rd_ptr + PTR_W'(i)];
            end
        end
    end

    assign fwd_take = (state == S_IDLE) & cmd_ld_mem & ~wb_empty & fwd_hit;
    assign fwd_data = fwd_hit_data;
`else
    assign fwd_take = 1'b0;
    assign fwd_data = '0;
`endif

    assign busy = ((state == S_IDLE) & cmd_ld_mem & ~fwd_take)
                | (state == S_DRAIN)
                | ((state == S_RD_WAIT) & ~mem_rvalid)
                | st_full;

    assign accept     = ~busy;
    assign mem_wvalid = ~wb_empty;
    assign push       = accept & cmd_st;
    assign pop        = mem_wvalid & mem_wready;

    assign wb_count_nxt = wb_count + CNT_W'(push) - CNT_W'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            mbr_q     <= '0;
            mem_rreq  <= 1'b0;
            mem_raddr <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_ld_mem) begin
                        if (fwd_take) begin
                            if (accept) mbr_q <= fwd_data;
                        end else if (wb_empty) begin
                            state     <= S_RD_WAIT;
                            mem_rreq  <= 1'b1;
                            mem_raddr <= addr_in;
                        end else begin
                            state <= S_DRAIN;
                        end
                    end else if (cmd_ld_acc && accept) begin
                        mbr_q <= from_ACC;
                    end
                end
                S_DRAIN: begin
                    if (wb_count_nxt == '0) begin
                        state     <= S_RD_WAIT;
                        mem_rreq  <= 1'b1;
                        mem_raddr <= addr_in;
                    end
                end
                S_RD_WAIT: begin
                    // A store stalled on a full FIFO holds the read open; rreq stays high.
                    if (accept) begin
                        state    <= S_IDLE;
                        mem_rreq <= 1'b0;
                        mbr_q    <= from_memory;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    mem_rreq <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            wb_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            wb_count <= wb_count_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            wb_data[wr_ptr] <= mbr_q;
            wb_addr[wr_ptr] <= addr_in;
        end
    end

    // Gated so stale storage never shows on the bus after reset.
    assign to_memory = mem_wvalid ? wb_data[rd_ptr] : '0;
    assign mem_waddr = mem_wvalid ? wb_addr[rd_ptr] : '0;

    assign to_PC  = mbr_q[ADDR_W-1:0];
    assign to_IR  = mbr_q[DATA_W-1:ADDR_W];
    assign to_BR  = mbr_q;
    assign to_MAR = mbr_q[ADDR_W-1:0];

endmodule

// File: tb/tb_mem_buffer_unit.sv
// Directed self-checking bench for mem_buffer_unit (default parameters).
module tb_mem_buffer_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] control_signal;
    logic [7:0]  addr_in;
    logic [15:0] from_memory;
    logic        mem_rvalid;
    logic [15:0] from_ACC;
    logic        mem_rreq;
    logic [7:0]  mem_raddr;
    logic        mem_wvalid;
    logic        mem_wready;
    logic [15:0] to_memory;
    logic [7:0]  mem_waddr;
    logic        busy;
    logic [7:0]  to_PC;
    logic [7:0]  to_IR;
    logic [15:0] to_BR;
    logic [7:0]  to_MAR;

    int n_tests = 0;
    int n_fail  = 0;

    mem_buffer_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .control_signal (control_signal),
        .addr_in        (addr_in),
        .from_memory    (from_memory),
        .mem_rvalid     (mem_rvalid),
        .from_ACC       (from_ACC),
        .mem_rreq       (mem_rreq),
        .mem_raddr      (mem_raddr),
        .mem_wvalid     (mem_wvalid),
        .mem_wready     (mem_wready),
        .to_memory      (to_memory),
        .mem_waddr      (mem_waddr),
        .busy           (busy),
        .to_PC          (to_PC),
        .to_IR          (to_IR),
        .to_BR          (to_BR),
        .to_MAR         (to_MAR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic ld_mem, input logic ld_acc, input logic st, input logic [7:0] ad);
        control_signal     = '0;
        control_signal[3]  = ld_mem;
        control_signal[20] = ld_acc;
        control_signal[19] = st;
        addr_in            = ad;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        control_signal = '0;
        addr_in     = '0;
        from_memory = '0;
        mem_rvalid  = 1'b0;
        from_ACC    = '0;
        mem_wready  = 1'b0;
        tick();
        tick();
        check_eq("rst_busy",   32'(busy),       0);
        check_eq("rst_rreq",   32'(mem_rreq),   0);
        check_eq("rst_wvalid", 32'(mem_wvalid), 0);
        check_eq("rst_br",     32'(to_BR),      0);
        rst_n = 1'b1;
        tick();

        // Reset while a read is outstanding
        set_cmd(1, 0, 0, 8'h20);
        tick();
        check_eq("rdw_rreq",  32'(mem_rreq),  1);
        check_eq("rdw_raddr", 32'(mem_raddr), 32'h20);
        check_eq("rdw_busy",  32'(busy),      1);
        tick();
        set_cmd(0, 0, 0, 8'h00);
        rst_n = 1'b0;
        #1;
        check_eq("rst2_rreq",  32'(mem_rreq),  0);
        check_eq("rst2_raddr", 32'(mem_raddr), 0);
        check_eq("rst2_busy",  32'(busy),      0);
        check_eq("rst2_pc",    32'(to_PC),     0);
        tick();
        rst_n = 1'b1;
        tick();
        from_ACC = 16'h1234;
        set_cmd(0, 1, 0, 8'h00);
        tick();
        set_cmd(0, 0, 0, 8'h00);
        check_eq("acc_ir",  32'(to_IR),  32'h12);
        check_eq("acc_pc",  32'(to_PC),  32'h34);
        check_eq("acc_mar", 32'(to_MAR), 32'h34);

        // Posted store held until mem_wready
        from_ACC = 16'hBEEF;
        set_cmd(0, 1, 0, 8'h00);
        tick();
        set_cmd(0, 0, 1, 8'h10);
        tick();
        set_cmd(0, 0, 0, 8'h00);
        check_eq("st_wvalid", 32'(mem_wvalid), 1);
        check_eq("st_data",   32'(to_memory),  32'hBEEF);
        check_eq("st_addr",   32'(mem_waddr),  32'h10);
        tick();
        tick();
        check_eq("st_hold_v", 32'(mem_wvalid), 1);
        check_eq("st_hold_d", 32'(to_memory),  32'hBEEF);
        mem_wready = 1'b1;
        tick();
        mem_wready = 1'b0;
        check_eq("st_popped", 32'(mem_wvalid), 0);

        // Fill the FIFO; the fifth store stalls
        from_ACC = 16'h0100;
        set_cmd(0, 1, 0, 8'h00);
        tick();
        for (int i = 0; i < 4; i++) begin
            from_ACC = 16'h0101 + 16'(i);
            set_cmd(0, 1, 1, 8'h40 + 8'(i));
            tick();
        end
        from_ACC = 16'h0105;
        set_cmd(0, 1, 1, 8'h44);
        #1;
        check_eq("full_busy", 32'(busy), 1);
        tick();
        check_eq("full_busy2", 32'(busy),      1);
        check_eq("full_defer", 32'(to_BR),     32'h0104);
        check_eq("full_head",  32'(to_memory), 32'h0100);
        check_eq("full_haddr", 32'(mem_waddr), 32'h40);
        mem_wready = 1'b1;
        tick();
        mem_wready = 1'b0;
        check_eq("full_free", 32'(busy), 0);
        tick();
        set_cmd(0, 0, 0, 8'h00);
        check_eq("full_acc", 32'(to_BR), 32'h0105);
        for (int i = 1; i < 5; i++) begin
            check_eq("drain_data", 32'(to_memory), 32'h0100 + 32'(i));
            check_eq("drain_addr", 32'(mem_waddr), 32'h40 + 32'(i));
            mem_wready = 1'b1;
            tick();
        end
        mem_wready = 1'b0;
        check_eq("drain_empty", 32'(mem_wvalid), 0);

        // Read with three wait states
        from_memory = 16'hA55A;
        set_cmd(1, 0, 0, 8'h20);
        for (int k = 0; k < 3; k++) begin
            #1;
            check_eq("rd_busy", 32'(busy), 1);
            if (k > 0) check_eq("rd_rreq", 32'(mem_rreq), 1);
            tick();
        end
        mem_rvalid = 1'b1;
        #1;
        check_eq("rd_busy_lo", 32'(busy),      0);
        check_eq("rd_raddr",   32'(mem_raddr), 32'h20);
        tick();
        mem_rvalid = 1'b0;
        set_cmd(0, 0, 0, 8'h00);
        check_eq("rd_data",   32'(to_BR),    32'hA55A);
        check_eq("rd_rreq_0", 32'(mem_rreq), 0);

        // Stray rvalid in IDLE is ignored
        from_memory = 16'hFFFF;
        mem_rvalid  = 1'b1;
        tick();
        mem_rvalid  = 1'b0;
        check_eq("stray_rvalid", 32'(to_BR), 32'hA55A);

        // Load from an address still queued in the FIFO
        from_ACC = 16'h1111;
        set_cmd(0, 1, 0, 8'h00);
        tick();
        set_cmd(0, 0, 1, 8'h30);
        tick();
        from_memory = 16'hDEAD;
        set_cmd(1, 0, 0, 8'h30);
`ifdef MBR_FWD_EN
        #1;
        check_eq("fwd_busy", 32'(busy), 0);
        tick();
        set_cmd(0, 0, 0, 8'h00);
        check_eq("fwd_data", 32'(to_BR),    32'h1111);
        check_eq("fwd_rreq", 32'(mem_rreq), 0);
        tick();
        check_eq("fwd_rreq2", 32'(mem_rreq), 0);
        mem_wready = 1'b1;
        tick();
        mem_wready = 1'b0;
        check_eq("fwd_drained", 32'(mem_wvalid), 0);
`else
        #1;
        check_eq("raw_busy", 32'(busy), 1);
        tick();
        check_eq("raw_drain_rreq", 32'(mem_rreq),   0);
        check_eq("raw_drain_wv",   32'(mem_wvalid), 1);
        check_eq("raw_drain_busy", 32'(busy),       1);
        mem_wready = 1'b1;
        tick();
        mem_wready = 1'b0;
        check_eq("raw_wv_done", 32'(mem_wvalid), 0);
        check_eq("raw_rreq",    32'(mem_rreq),   1);
        check_eq("raw_raddr",   32'(mem_raddr),  32'h30);
        mem_rvalid = 1'b1;
        #1;
        check_eq("raw_busy_lo", 32'(busy), 0);
        tick();
        mem_rvalid = 1'b0;
        set_cmd(0, 0, 0, 8'h00);
        check_eq("raw_data", 32'(to_BR), 32'hDEAD);
`endif

        // LD_MEM + LD_ACC + ST in one command
        from_ACC = 16'h0005;
        set_cmd(0, 1, 0, 8'h00);
        tick();
        from_ACC    = 16'h7777;
        from_memory = 16'h9999;
        set_cmd(1, 1, 1, 8'h50);
        tick();
        check_eq("mix_nostore", 32'(mem_wvalid), 0);
        check_eq("mix_noacc",   32'(to_BR),      32'h0005);
        tick();
        mem_rvalid = 1'b1;
        #1;
        check_eq("mix_busy_lo", 32'(busy), 0);
        tick();
        mem_rvalid = 1'b0;
        set_cmd(0, 0, 0, 8'h00);
        check_eq("mix_br",     32'(to_BR),      32'h9999);
        check_eq("mix_wvalid", 32'(mem_wvalid), 1);
        check_eq("mix_wdata",  32'(to_memory),  32'h0005);
        check_eq("mix_waddr",  32'(mem_waddr),  32'h50);
        mem_wready = 1'b1;
        tick();
        mem_wready = 1'b0;
        check_eq("mix_drained", 32'(mem_wvalid), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
